// File: rtl/status_uart_tx_pkg.sv
// Shared types and constants for the status uplink transmitter.
// STATUS_TX_PARITY_EN adds an even-parity bit to every byte of the frame.
package status_uart_tx_pkg;

  localparam int unsigned FRAME_BYTES       = 5;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int unsigned LIGHT   = 0;
  localparam int unsigned HEATER  = 1;
  localparam int unsigned COOLER  = 2;
  localparam int unsigned ALARM   = 3;
  localparam int unsigned PLUG    = 4;
  localparam int unsigned DEVCTRL = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } txState_t;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_SEND,
    FR_DONE
  } frameState_t;

  function automatic logic [7:0] frameChecksum(input logic [7:0] status,
                                               input logic [7:0] curTemp,
                                               input logic [7:0] desTemp);
    return status ^ curTemp ^ desTemp;
  endfunction

endpackage

// File: rtl/status_uart_tx_byte.sv
// Single-byte UART serializer: start, 8 data bits LSB first, optional even
// parity (STATUS_TX_PARITY_EN), stop. A start seen on the last stop cycle chains bytes.
module uart_tx_byte
  import status_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byteDone
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  txState_t         state, nextState;
  logic [CNT_W-1:0] baudCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       dataReg;
  logic             bitEnd;
  logic             loadByte;

  assign bitEnd   = (baudCnt == LAST_CNT);
  assign loadByte = start && ((state == IDLE) || ((state == STOP) && bitEnd));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (start) nextState = START;
      START: if (bitEnd) nextState = DATA;
      DATA:
        if (bitEnd && (bitIdx == 3'd7)) begin
`ifdef STATUS_TX_PARITY_EN
          nextState = PARITY;
`else
          nextState = STOP;
`endif
        end
`ifdef STATUS_TX_PARITY_EN
      PARITY: if (bitEnd) nextState = STOP;
`endif
      STOP:  if (bitEnd) nextState = start ? START : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    tx       = 1'b1;
    byteDone = (state == STOP) && bitEnd;
    case (state)
      START: tx = 1'b0;
      DATA:  tx = dataReg[bitIdx];
`ifdef STATUS_TX_PARITY_EN
      PARITY: tx = ^dataReg;
`endif
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baudCnt <= '0;
      bitIdx  <= '0;
      dataReg <= '0;
    end else begin
      if ((state == IDLE) || bitEnd) baudCnt <= '0;
      else                           baudCnt <= baudCnt + 1'b1;

      if (loadByte) dataReg <= data;

      if ((state == DATA) && bitEnd)
        bitIdx <= (bitIdx == 3'd7) ? 3'd0 : bitIdx + 3'd1;
    end
  end

endmodule

// File: rtl/status_uart_tx.sv
// Status uplink: snapshots device outputs and temperatures into a 5-byte UART frame.
// STATUS_TX_PARITY_EN adds an even-parity bit per byte (55 bit times per frame).
module status_uart_tx
  import status_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lightOn,
  input  logic       heaterOn,
  input  logic       coolerOn,
  input  logic       alarm,
  input  logic       plugOn,
  input  logic       deviceControl,
  input  logic [7:0] currentTemp,
  input  logic [7:0] desiredTemp,
  input  logic       send_req,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  frameState_t state, nextState;
  logic [7:0]  statusByte;
  logic [5:0]  lastStatus;
  logic        trigger;
  logic        pending;
  logic        loadFrame;
  logic        restart;
  logic        lastByte;
  logic        advance;
  logic [2:0]  byteIdx;
  logic [2:0]  selIdx;
  logic [7:0]  snapStatus, snapCur, snapDes, snapSum;
  logic        txStart;
  logic [7:0]  txData;
  logic        byteDone;

  always_comb begin
    statusByte          = '0;
    statusByte[LIGHT]   = lightOn;
    statusByte[HEATER]  = heaterOn;
    statusByte[COOLER]  = coolerOn;
    statusByte[ALARM]   = alarm;
    statusByte[PLUG]    = plugOn;
    statusByte[DEVCTRL] = deviceControl;
  end

  assign trigger   = send_req || (statusByte[5:0] != lastStatus);
  // A request landing in the DONE cycle restarts directly rather than being dropped.
  assign restart   = pending || trigger;
  assign loadFrame = ((state == FR_IDLE) && trigger) || ((state == FR_DONE) && restart);
  assign lastByte  = (byteIdx == 3'(FRAME_BYTES - 1));
  assign advance   = (state == FR_SEND) && byteDone && !lastByte;
  assign txStart   = loadFrame || advance;
  assign selIdx    = loadFrame ? 3'd0 : byteIdx + 3'd1;

  always_comb begin
    case (selIdx)
      3'd1:    txData = snapStatus;
      3'd2:    txData = snapCur;
      3'd3:    txData = snapDes;
      3'd4:    txData = snapSum;
      default: txData = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FR_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      FR_IDLE: if (trigger) nextState = FR_SEND;
      FR_SEND: if (byteDone && lastByte) nextState = FR_DONE;
      FR_DONE: nextState = restart ? FR_SEND : FR_IDLE;
      default: nextState = FR_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == FR_SEND);
    frame_done = (state == FR_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastStatus <= '0;
      pending    <= 1'b0;
      byteIdx    <= '0;
      snapStatus <= '0;
      snapCur    <= '0;
      snapDes    <= '0;
      snapSum    <= '0;
    end else if (loadFrame) begin
      lastStatus <= statusByte[5:0];
      pending    <= 1'b0;
      byteIdx    <= '0;
      snapStatus <= statusByte;
      snapCur    <= currentTemp;
      snapDes    <= desiredTemp;
      snapSum    <= frameChecksum(statusByte, currentTemp, desiredTemp);
    end else begin
      if (advance) byteIdx <= byteIdx + 3'd1;
      if ((state == FR_SEND) && trigger) pending <= 1'b1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk     (clk),
    .reset   (reset),
    .start   (txStart),
    .data    (txData),
    .tx      (tx),
    .byteDone(byteDone)
  );

endmodule
